// File: rtl/bus_master_arbiter.sv
// rtl/bus_master_arbiter.sv - round-robin arbiter sharing the register bus between several masters
module bus_master_arbiter #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MST-1:0]        mst_req,
    input  logic [NUM_MST-1:0]        mst_op,
    input  logic [NUM_MST*ADDR_W-1:0] mst_addr,
    input  logic [NUM_MST*DATA_W-1:0] mst_wr_data,
    output logic [NUM_MST-1:0]        mst_ack,
    output logic [NUM_MST-1:0]        mst_rd_valid,
    output logic [DATA_W-1:0]         mst_rd_data,
    output logic                      bus_cmd_valid,
    output logic                      bus_op,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wr_data,
    input  logic [DATA_W-1:0]         bus_rd_data,
    output logic                      busy
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    last_gnt;
    logic [IDX_W-1:0]    win;
    logic                win_op;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                found;
    logic                op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    rd_cnt;
    logic [NUM_MST-1:0]  rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Rotating priority: scan from the master after the last winner, wrapping once.
    always_comb begin
        found    = 1'b0;
        win      = last_gnt;
        win_op   = 1'b0;
        win_addr = '0;
        win_data = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            int j;
            j = (int'(last_gnt) + k) % NUM_MST;
            if (!found && mst_req[j]) begin
                found    = 1'b1;
                win      = IDX_W'(j);
                win_op   = mst_op[j];
                win_addr = mst_addr[j*ADDR_W +: ADDR_W];
                win_data = mst_wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = op_q ? IDLE : WAIT_RD;
            WAIT_RD: if (rd_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_gnt   <= IDX_W'(NUM_MST - 1);
            op_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_cnt     <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state      <= state_nxt;
            rd_valid_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        op_q     <= win_op;
                        addr_q   <= win_addr;
                        wdata_q  <= win_data;
                        last_gnt <= win;
                    end
                end
                ISSUE: begin
                    if (!op_q) rd_cnt <= CNT_W'(RD_LAT - 1);
                end
                WAIT_RD: begin
                    // last_gnt still names the read issuer until the next arbitration.
                    if (rd_cnt == '0) begin
                        rd_data_q            <= bus_rd_data;
                        rd_valid_q[last_gnt] <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_cmd_valid = (state == ISSUE);
        bus_op        = 1'b0;
        bus_addr      = '0;
        bus_wr_data   = '0;
        mst_ack       = '0;
        if (state == ISSUE) begin
            bus_op            = op_q;
            bus_addr          = addr_q;
            bus_wr_data       = wdata_q;
            mst_ack[last_gnt] = 1'b1;
        end
    end

    assign busy         = (state != IDLE);
    assign mst_rd_valid = rd_valid_q;
    assign mst_rd_data  = rd_data_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb/tb_bus_master_arbiter.sv - scoreboard bench for bus_master_arbiter at two parameter points
module tb_bus_master_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        int          cyc;
        int          mst;
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        op;
        logic [15:0] addr;
        logic [15:0] data;
    } cmd_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } bus_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int got, input int want);
        checks++;
        failures++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    endtask

    // Harness 0: 2 masters, RD_LAT=1. Harness 1: 3 masters, RD_LAT=3.
    for (genvar g = 0; g < 2; g++) begin : h
        localparam int NM  = (g == 0) ? 2 : 3;
        localparam int LAT = (g == 0) ? 1 : 3;

        logic               rst_n;
        logic [NM-1:0]      req, op, ack, rd_valid;
        logic [NM*AW-1:0]   addr_p;
        logic [NM*DW-1:0]   wdata_p;
        logic [DW-1:0]      rd_data, bus_wr_data, bus_rd_data;
        logic [AW-1:0]      bus_addr;
        logic               cmd_valid, bus_op, busy;

        bit          done_h = 1'b0;
        int          cyc = 0;
        int          gap_pct = 0;
        int          last, free_c, busy_from;
        logic [15:0] last_rd;
        bit          use_ovr = 1'b0;
        logic [15:0] ovr = 16'h0;
        cmd_t        cq [NM][$];
        exp_t        expq [$];
        exp_t        rdq [$];
        bus_t        busq [$];

        bus_master_arbiter #(
            .NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .mst_req(req), .mst_op(op), .mst_addr(addr_p), .mst_wr_data(wdata_p),
            .mst_ack(ack), .mst_rd_valid(rd_valid), .mst_rd_data(rd_data),
            .bus_cmd_valid(cmd_valid), .bus_op(bus_op), .bus_addr(bus_addr),
            .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .busy(busy)
        );

        initial forever begin
            @(posedge clk);
            cyc++;
        end

        task automatic model_reset();
            last      = NM - 1;
            free_c    = 0;
            busy_from = 0;
            last_rd   = 16'h0;
            expq.delete();
            rdq.delete();
            busq.delete();
        endtask

        task automatic push_cmd(input int m, input logic o, input logic [15:0] a, input logic [15:0] d);
            cmd_t c;
            c.op = o; c.addr = a; c.data = d;
            cq[m].push_back(c);
        endtask

        function automatic bit pending();
            bit p = 1'b0;
            for (int m = 0; m < NM; m++) if (cq[m].size() != 0) p = 1'b1;
            return p;
        endfunction

        task automatic wait_idle(input string ph);
            int n = 0;
            while (n < 3000 && (pending() || busy || req != '0 || expq.size() != 0 || rdq.size() != 0)) begin
                @(posedge clk);
                n++;
            end
            if (n >= 3000) fail_now($sformatf("h%0d_%s_timeout", g, ph), n, 3000);
            repeat (2) @(posedge clk);
        endtask

        // Masters: present the head command, hold until acked, then drop or refresh.
        for (genvar m = 0; m < NM; m++) begin : drv
            logic          r, o;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            assign req[m]               = r;
            assign op[m]                = o;
            assign addr_p[m*AW +: AW]   = a;
            assign wdata_p[m*DW +: DW]  = d;

            initial begin
                bit   acked;
                cmd_t c;
                r = 1'b0; o = 1'b0; a = '0; d = '0; acked = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (!rst_n) begin
                        r = 1'b0; o = 1'b0; a = '0; d = '0; acked = 1'b0;
                    end else begin
                        if (r && acked) begin
                            void'(cq[m].pop_front());
                            r = 1'b0;
                        end
                        if (!r && cq[m].size() != 0 && $urandom_range(99) >= gap_pct) begin
                            c = cq[m][0];
                            r = 1'b1; o = c.op; a = c.addr; d = c.data;
                        end else if (!r) begin
                            o = 1'($urandom); a = 16'($urandom); d = 16'($urandom);
                        end
                    end
                    @(negedge clk);
                    acked = ack[m];
                end
            end
        end

        // Reference model: bus is free from cycle free_c; arbitrate by rotating from last+1.
        initial begin
            exp_t e;
            bus_t b;
            int   w;
            forever begin
                @(negedge clk);
                if (rst_n && cyc >= free_c && req != '0) begin
                    w = -1;
                    for (int k = 1; k <= NM; k++) begin
                        int j;
                        j = (last + k) % NM;
                        if (w < 0 && req[j]) w = j;
                    end
                    e.cyc  = cyc + 1;
                    e.mst  = w;
                    e.op   = op[w];
                    e.addr = addr_p[w*AW +: AW];
                    e.data = wdata_p[w*DW +: DW];
                    expq.push_back(e);
                    last      = w;
                    busy_from = cyc + 1;
                    if (op[w]) begin
                        free_c = cyc + 2;
                    end else begin
                        b.cyc  = cyc + 1 + LAT;
                        b.data = use_ovr ? ovr : 16'($urandom);
                        busq.push_back(b);
                        e.cyc  = cyc + 2 + LAT;
                        e.data = b.data;
                        rdq.push_back(e);
                        free_c = cyc + LAT + 2;
                    end
                end
            end
        end

        // Bus-side read data: correct only in the cycle the model says it is due.
        initial begin
            bus_rd_data = '0;
            forever begin
                @(posedge clk);
                #1;
                while (busq.size() != 0 && busq[0].cyc < cyc) void'(busq.pop_front());
                if (busq.size() != 0 && busq[0].cyc == cyc) bus_rd_data = busq[0].data;
                else bus_rd_data = 16'($urandom);
            end
        end

        // Monitor
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk($sformatf("h%0d_busy", g), busy, (cyc >= busy_from && cyc < free_c));
                    if (cmd_valid) begin
                        if (expq.size() == 0 || expq[0].cyc != cyc) begin
                            chk($sformatf("h%0d_cmd_unexpected", g), cmd_valid, 1'b0);
                        end else begin
                            e = expq.pop_front();
                            chk($sformatf("h%0d_ack", g), ack, 64'(1) << e.mst);
                            chk($sformatf("h%0d_op", g), bus_op, e.op);
                            chk($sformatf("h%0d_addr", g), bus_addr, e.addr);
                            chk($sformatf("h%0d_wdata", g), bus_wr_data, e.data);
                        end
                    end else begin
                        chk($sformatf("h%0d_idle_bus", g), {ack, bus_op, bus_addr, bus_wr_data}, 64'h0);
                    end
                    if (expq.size() != 0 && expq[0].cyc < cyc) begin
                        fail_now($sformatf("h%0d_cmd_missing", g), cyc, expq[0].cyc);
                        void'(expq.pop_front());
                    end
                    if (rd_valid != '0) begin
                        if (rdq.size() == 0 || rdq[0].cyc != cyc) begin
                            chk($sformatf("h%0d_rd_unexpected", g), rd_valid, 64'h0);
                        end else begin
                            e = rdq.pop_front();
                            chk($sformatf("h%0d_rd_valid", g), rd_valid, 64'(1) << e.mst);
                            chk($sformatf("h%0d_rd_data", g), rd_data, e.data);
                            last_rd = e.data;
                        end
                    end else begin
                        chk($sformatf("h%0d_rd_hold", g), rd_data, last_rd);
                    end
                    if (rdq.size() != 0 && rdq[0].cyc < cyc) begin
                        fail_now($sformatf("h%0d_rd_missing", g), cyc, rdq[0].cyc);
                        void'(rdq.pop_front());
                    end
                end
            end
        end

        initial begin
            int n;
            rst_n = 1'b0;
            model_reset();
            repeat (3) @(posedge clk);
            #1;
            chk($sformatf("h%0d_reset_outputs", g),
                {ack, rd_valid, rd_data, cmd_valid, bus_op, bus_addr, bus_wr_data, busy}, 64'h0);
            @(posedge clk);
            #2 rst_n = 1'b1;

            push_cmd(0, 1'b1, 16'h0009, 16'h0001);
            wait_idle("single_write");

            use_ovr = 1'b1;
            ovr     = 16'h00A5;
            push_cmd(1, 1'b0, 16'h4009, 16'h0000);
            wait_idle("single_read");
            use_ovr = 1'b0;

            for (int i = 0; i < 6; i++) begin
                push_cmd(0, 1'b1, 16'(16'h0100 + i), 16'($urandom));
                push_cmd(1, 1'b1, 16'(16'h0200 + i), 16'($urandom));
            end
            wait_idle("alternating_writes");

            for (int i = 0; i < 6; i++) push_cmd(0, 1'b0, 16'(16'h0300 + i), 16'($urandom));
            repeat (5) @(posedge clk);
            push_cmd(1, 1'b1, 16'h0777, 16'hBEEF);
            wait_idle("continuous_vs_single");

            gap_pct = 40;
            for (int m = 0; m < NM; m++)
                for (int i = 0; i < 12; i++)
                    push_cmd(m, 1'($urandom), 16'($urandom), 16'($urandom));
            wait_idle("random_mix");
            gap_pct = 0;

            for (int m = 0; m < NM; m++) push_cmd(m, 1'b1, 16'(16'h0A00 + m), 16'(m));
            wait_idle("all_request");

            push_cmd(1, 1'b0, 16'h4009, 16'h0000);
            n = 0;
            while (n < 200 && !(cmd_valid && !bus_op)) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) fail_now($sformatf("h%0d_rd_cmd_timeout", g), n, 200);
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk($sformatf("h%0d_async_reset_outputs", g),
                {ack, rd_valid, rd_data, cmd_valid, bus_op, bus_addr, bus_wr_data, busy}, 64'h0);
            for (int m = 0; m < NM; m++) cq[m].delete();
            model_reset();
            repeat (3) @(posedge clk);
            #2 rst_n = 1'b1;
            repeat (LAT + 3) @(posedge clk);

            for (int m = NM - 1; m >= 0; m--) push_cmd(m, 1'b1, 16'(16'h0B00 + m), 16'(16'h1000 + m));
            wait_idle("post_reset_grants");

            done_h = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (n < 40000 && !(h[0].done_h && h[1].done_h)) begin
            @(posedge clk);
            n++;
        end
        if (n >= 40000) fail_now("global_timeout", n, 40000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
